// File: rtl/m3_sopc_pio_pkg.sv
// Shared constants for the generic Avalon-MM PIO slave: register word addresses and
// edge-capture mode encodings.
package m3_sopc_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/m3_sopc_pio_sync.sv
// Multi-stage flop synchroniser for the asynchronous PIO pin inputs; all stages clear to 0
// on reset.
module m3_sopc_pio_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/m3_sopc_pio_gen.sv
// Parametrised Avalon-MM PIO slave: bidirectional port with per-bit direction, atomic set/clear,
// synchronised inputs, armed edge capture and a registered maskable level interrupt.
module m3_sopc_pio_gen
  import m3_sopc_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam logic [2:0] ArmLast = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [WIDTH-1:0] in_prev_q;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_raw, edge_hit, clr, wd, rdata;
  logic [2:0]       arm_cnt_q, arm_cnt_d;
  logic             arm, we, irq_q;

  m3_sopc_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (in_sync)
  );

  assign we = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_unused_wd
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

  // Edge detection stays off until the synchroniser and in_prev hold real pin values,
  // so pins held high through reset cannot look like a rising edge.
  assign arm       = (arm_cnt_q == ArmLast);
  assign arm_cnt_d = arm ? arm_cnt_q : arm_cnt_q + 3'd1;

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_raw = in_sync & ~in_prev_q;
      EDGE_FALL: edge_raw = ~in_sync & in_prev_q;
      default:   edge_raw = in_sync ^ in_prev_q;
    endcase
    edge_hit = arm ? (edge_raw & ~dir_q) : '0;
  end

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr    = '0;
    if (we) begin
      case (address)
        ADDR_DATA:    out_d  = wd;
        ADDR_DIR:     dir_d  = wd;
        ADDR_IRQMASK: mask_d = wd;
        ADDR_EDGECAP: clr    = wd;
        ADDR_OUTSET:  out_d  = out_q | wd;
        ADDR_OUTCLR:  out_d  = out_q & ~wd;
        default:      ;
      endcase
    end
    // A fresh edge wins over a simultaneous write-one-to-clear.
    ecap_d = (ecap_q & ~clr) | edge_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= RESET_OUT;
      dir_q     <= RESET_DIR;
      mask_q    <= '0;
      ecap_q    <= '0;
      in_prev_q <= '0;
      arm_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      ecap_q    <= ecap_d;
      in_prev_q <= in_sync;
      arm_cnt_q <= arm_cnt_d;
      irq_q     <= |(ecap_q & mask_q);
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_DATA:    rdata = (dir_q & out_q) | (~dir_q & in_sync);
      ADDR_DIR:     rdata = dir_q;
      ADDR_IRQMASK: rdata = mask_q;
      ADDR_EDGECAP: rdata = ecap_q;
      default:      rdata = '0;
    endcase
  end

  assign readdata = 32'(rdata);
  assign out_port = out_q;
  assign oe_port  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_m3_sopc_pio_gen.sv
// Self-checking bench: two PIO instances (8-bit rising, 32-bit any-edge) on one bus, checked
// every cycle against a history-based model, plus directed literal checks.
module tb_m3_sopc_pio_gen;

  localparam int unsigned S8  = 2;
  localparam int unsigned S32 = 3;
  localparam logic [7:0]  RO8  = 8'hA5;
  localparam logic [7:0]  RD8  = 8'h00;
  localparam logic [31:0] RO32 = 32'hDEAD_BEEF;
  localparam logic [31:0] RD32 = 32'h0F00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in8 = '0, out8, oe8;
  logic [31:0] in32 = '0, out32, oe32, rd8, rd32;
  logic        irq8, irq32;

  int unsigned n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  m3_sopc_pio_gen #(
    .WIDTH(8), .RESET_OUT(RO8), .RESET_DIR(RD8), .EDGE_TYPE(0), .SYNC_STAGES(S8)
  ) dut8 (
    .clk(clk), .reset_n(rst_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd8), .in_port(in8),
    .out_port(out8), .oe_port(oe8), .irq(irq8)
  );

  m3_sopc_pio_gen #(
    .WIDTH(32), .RESET_OUT(RO32), .RESET_DIR(RD32), .EDGE_TYPE(2), .SYNC_STAGES(S32)
  ) dut32 (
    .clk(clk), .reset_n(rst_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd32), .in_port(in32),
    .out_port(out32), .oe_port(oe32), .irq(irq32)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Pin history: h[k-1] is the pin value sampled at the k-th clock edge after reset release.
  logic [31:0] h0[$], h1[$];
  logic [31:0] m_out[2], m_dir[2], m_mask[2], m_ecap[2];
  logic        m_irq[2];
  int          m_n[2];

  function automatic int stg(int d);
    return (d == 0) ? int'(S8) : int'(S32);
  endfunction

  function automatic logic [31:0] wm(int d);
    return (d == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] in_at(int d, int k);
    if (k < 1) return '0;
    return (d == 0) ? h0[k-1] : h1[k-1];
  endfunction

  function automatic void model_reset(int d);
    m_out[d]  = (d == 0) ? {24'h0, RO8} : RO32;
    m_dir[d]  = (d == 0) ? {24'h0, RD8} : RD32;
    m_mask[d] = '0;
    m_ecap[d] = '0;
    m_irq[d]  = 1'b0;
    m_n[d]    = 0;
    if (d == 0) h0.delete(); else h1.delete();
  endfunction

  function automatic void model_step(int d);
    int          n = m_n[d];
    int          s = stg(d);
    logic [31:0] cur = in_at(d, n - s + 1);
    logic [31:0] prv = in_at(d, n - s);
    logic [31:0] ev, wd, clr;
    logic        we = chipselect && !write_n;
    if (d == 0) ev = cur & ~prv;
    else        ev = cur ^ prv;
    ev = (n >= s + 1) ? (ev & ~m_dir[d] & wm(d)) : '0;
    wd  = writedata & wm(d);
    clr = (we && address == 3'd3) ? wd : '0;
    m_irq[d]  = |(m_ecap[d] & m_mask[d]);
    m_ecap[d] = (m_ecap[d] & ~clr) | ev;
    if (we) begin
      case (address)
        3'd0: m_out[d] = wd;
        3'd1: m_dir[d] = wd;
        3'd2: m_mask[d] = wd;
        3'd4: m_out[d] = m_out[d] | wd;
        3'd5: m_out[d] = m_out[d] & ~wd;
        default: ;
      endcase
    end
    if (d == 0) h0.push_back({24'h0, in8});
    else        h1.push_back(in32);
    m_n[d] = n + 1;
  endfunction

  function automatic logic [31:0] model_read(int d);
    logic [31:0] sync_v = in_at(d, m_n[d] - stg(d) + 1);
    case (address)
      3'd0: return ((m_dir[d] & m_out[d]) | (~m_dir[d] & sync_v)) & wm(d);
      3'd1: return m_dir[d];
      3'd2: return m_mask[d];
      3'd3: return m_ecap[d];
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset(d);
      else        model_step(d);
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(posedge clk);
    #1;
    check("m_out8",  {24'h0, out8}, m_out[0]);
    check("m_oe8",   {24'h0, oe8},  m_dir[0]);
    check("m_irq8",  {31'h0, irq8}, {31'h0, m_irq[0]});
    check("m_rd8",   rd8,           model_read(0));
    check("m_out32", out32,         m_out[1]);
    check("m_oe32",  oe32,          m_dir[1]);
    check("m_irq32", {31'h0, irq32}, {31'h0, m_irq[1]});
    check("m_rd32",  rd32,          model_read(1));
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset state
    check("t1_out8", {24'h0, out8}, 32'hA5);
    check("t1_oe8", {24'h0, oe8}, 32'h0);
    check("t1_irq8", {31'h0, irq8}, 32'h0);
    check("t1_out32", out32, 32'hDEAD_BEEF);
    for (int a = 1; a <= 3; a++) begin
      rd(3'(a));
      check("t1_rd8", rd8, 32'h0);
    end
    @(negedge clk);

    // 2: data/set/clear
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'h3C);
    check("t2_out_3c", {24'h0, out8}, 32'h3C);
    wr(3'd4, 32'h81);
    check("t2_out_bd", {24'h0, out8}, 32'hBD);
    wr(3'd5, 32'h04);
    check("t2_out_b9", {24'h0, out8}, 32'hB9);
    check("t2_out32_b9", out32, 32'hB9);
    rd(3'd0); check("t2_rd_data", rd8, 32'hB9);
    rd(3'd4); check("t2_rd_outset", rd8, 32'h0);
    @(negedge clk);

    // 3: input latency and edge capture
    wr(3'd1, 32'h0);
    repeat (2) @(negedge clk);
    address = 3'd0; in8 = 8'h01;
    @(negedge clk); rd(3'd0); check("t3_data_1clk", rd8, 32'h00);
    @(negedge clk); rd(3'd0); check("t3_data_2clk", rd8, 32'h01);
    rd(3'd3); check("t3_ecap_2clk", rd8, 32'h00);
    @(negedge clk); rd(3'd3); check("t3_ecap_3clk", rd8, 32'h01);
    check("t3_irq_masked", {31'h0, irq8}, 32'h0);

    // 4: W1C racing a new edge
    @(negedge clk);
    wr(3'd2, 32'h1);
    @(negedge clk); check("t4_irq_on", {31'h0, irq8}, 32'h1);
    in8 = 8'h00;
    repeat (4) @(negedge clk);
    rd(3'd3); check("t4_ecap_fall_ignored", rd8, 32'h01);
    in8 = 8'h01;
    @(negedge clk);
    @(negedge clk);
    wr(3'd3, 32'h1);
    rd(3'd3); check("t4_ecap_race", rd8, 32'h01);
    check("t4_irq_race", {31'h0, irq8}, 32'h1);
    @(negedge clk); check("t4_irq_hold", {31'h0, irq8}, 32'h1);
    wr(3'd3, 32'h1);
    rd(3'd3); check("t4_ecap_clr", rd8, 32'h00);
    check("t4_irq_lag", {31'h0, irq8}, 32'h1);
    @(negedge clk); check("t4_irq_off", {31'h0, irq8}, 32'h0);

    // 5: async reset mid-operation, pins high through release
    rst_n = 1'b0; in8 = 8'hFF; in32 = 32'hFFFF_FFFF;
    #1;
    check("t5_async_out8", {24'h0, out8}, 32'hA5);
    rd(3'd1); check("t5_async_dir8", rd8, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wr(3'd2, 32'hFFFF_FFFF);
    address = 3'd3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_ecap8", rd8, 32'h0);
      check("t5_irq8", {31'h0, irq8}, 32'h0);
      check("t5_ecap32", rd32, 32'h0);
      check("t5_irq32", {31'h0, irq32}, 32'h0);
    end

    // 6: any-edge on 32 bits, direction gating, unmapped write
    wr(3'd1, 32'h0000_FFFF);
    in32 = 32'h0; in8 = 8'h00;
    repeat (6) @(negedge clk);
    rd(3'd3); check("t6_ecap32", rd32, 32'hFFFF_0000);
    check("t6_ecap8", rd8, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    check("t6_out32", out32, 32'hDEAD_BEEF);
    check("t6_oe32", oe32, 32'h0000_FFFF);
    rd(3'd3); check("t6_ecap32_kept", rd32, 32'hFFFF_0000);
    rd(3'd2); check("t6_mask32", rd32, 32'hFFFF_FFFF);
    rd(3'd6); check("t6_rd6", rd32, 32'h0);
    rd(3'd7); check("t6_rd7", rd32, 32'h0);
    check("t6_irq32", {31'h0, irq32}, 32'h1);

    // random traffic, pin activity and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      if ($urandom_range(0, 2) == 0) in8 = in8 ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) in32 = in32 ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) begin
        in8 = 8'($urandom);
        in32 = $urandom;
      end
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
